// File: rtl/audio_pkg.sv
// Shared audio-link definitions used by the DAC serializer and the ADC
// deserializer.
//   AUDIO_DATA_W    : default PCM sample width
//   channel_t       : I2S slot identity (DACLRCK/ADCLRCK low = left)
//   i2s_tx_state_t  : serializer/deserializer slot state machine
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  typedef enum logic [1:0] {
    S_PRIME,
    S_WAIT,
    S_SHIFT,
    S_PAD
  } i2s_tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with a separately kept occupancy count, so full
// and empty are unambiguous while the pointers simply wrap.
// rd_data shows the head entry combinationally (valid only when !empty).
//   i_clk, i_rst : clock, async active-high reset (empties the FIFO)
//   push/wr_data : write request; ignored while full
//   pop/rd_data  : read request; ignored while empty
//   full, empty  : occupancy flags
//   level        : current number of stored entries (0..DEPTH)
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; level/pointers define
  // which entries are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S transmit serializer for the codec DAC path, clocked by codec BCLK.
// Samples arrive over valid/ready into a small FIFO; at each DACLRCK edge a
// word is chosen and shifted out MSB-first on DACDAT (the codec skips the
// first BCLK of the slot, giving the I2S one-bit delay). Unused BCLKs are 0.
//   i_clk, i_rst  : BCLK, async active-high reset
//   i_enable      : play enable, sampled only at slot start
//   i_daclrck     : codec DACLRCK, 0 = left slot, 1 = right slot
//   i_data/i_valid/o_ready : sample input handshake
//   o_dacdat      : registered serial data to codec
//   o_underflow   : 1-cycle pulse when a slot needed a sample and FIFO was empty
//   o_overflow    : 1-cycle pulse when a sample was offered while full (dropped)
//   o_level       : FIFO occupancy
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W     = AUDIO_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit MONO_DUP   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_daclrck,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_dacdat,
  output logic                          o_underflow,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  i2s_tx_state_t     state_q, state_d;
  logic              lrck_q;
  logic              lrck_edge;
  channel_t          slot_ch;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] word;
  logic              dacdat_d;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (i_valid),
    .wr_data (i_data),
    .pop     (pop_req),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign o_ready = ~fifo_full;

  // The prime cycle only captures the current LRCK level, so a slot already
  // in progress at reset release is never sent as a partial word.
  assign lrck_edge = (state_q != S_PRIME) && (i_daclrck != lrck_q);
  assign slot_ch   = i_daclrck ? CH_RIGHT : CH_LEFT;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_PRIME;
    else       state_q <= state_d;
  end

  // Next-state logic; an LRCK edge restarts the word from any state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    state_d = state_q;
    if (lrck_edge) begin
      state_d = (DATA_W > 1) ? S_SHIFT : S_PAD;
    end else begin
      case (state_q)
        S_PRIME: state_d = S_WAIT;
        S_SHIFT: if (bit_cnt_q == CNT_W'(1)) state_d = S_PAD;
        default: state_d = state_q;
      endcase
    end
  end

  // Word selection and shift datapath.
  always_comb begin
    pop_req   = 1'b0;
    word      = '0;
    held_d    = held_q;
    dacdat_d  = 1'b0;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;

    if (lrck_edge && i_enable) begin
      if (!MONO_DUP || slot_ch == CH_LEFT) begin
        pop_req = 1'b1;
        word    = fifo_empty ? '0 : fifo_rd_data;
      end else begin
        word = held_q;
      end
    end
    // Left word (or silence when disabled) is what the mono right slot repeats.
    if (lrck_edge && slot_ch == CH_LEFT) held_d = word;

    if (lrck_edge) begin
      dacdat_d  = word[DATA_W-1];
      shreg_d   = word << 1;
      bit_cnt_d = CNT_W'(DATA_W - 1);
    end else if (state_q == S_SHIFT) begin
      dacdat_d  = shreg_q[DATA_W-1];
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrck_q      <= 1'b0;
      shreg_q     <= '0;
      held_q      <= '0;
      bit_cnt_q   <= '0;
      o_dacdat    <= 1'b0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      lrck_q      <= i_daclrck;
      shreg_q     <= shreg_d;
      held_q      <= held_d;
      bit_cnt_q   <= bit_cnt_d;
      o_dacdat    <= dacdat_d;
      o_underflow <= pop_req & fifo_empty;
      o_overflow  <= i_valid & ~o_ready;
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Directed bench: codec model with 32 BCLK per LRCK half, decoding with the
// I2S one-bit delay. dut_m uses MONO_DUP=1, dut_s uses MONO_DUP=0.
module tb_i2s_dac_serializer;

  logic        i_clk, i_rst, i_enable, i_daclrck;
  logic [15:0] i_data;
  logic        valid_m, valid_s;
  logic        ready_m, dacdat_m, uf_m, ovf_m;
  logic        ready_s, dacdat_s, uf_s, ovf_s;
  logic [2:0]  level_m, level_s;

  int n_cmp = 0;
  int n_bad = 0;
  int uf_cnt_m = 0;
  int uf_cnt_s = 0;
  int ovf_cnt_m = 0;

  i2s_dac_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .MONO_DUP(1'b1)) dut_m (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_daclrck(i_daclrck),
    .i_data(i_data), .i_valid(valid_m), .o_ready(ready_m), .o_dacdat(dacdat_m),
    .o_underflow(uf_m), .o_overflow(ovf_m), .o_level(level_m)
  );

  i2s_dac_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .MONO_DUP(1'b0)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_daclrck(i_daclrck),
    .i_data(i_data), .i_valid(valid_s), .o_ready(ready_s), .o_dacdat(dacdat_s),
    .o_underflow(uf_s), .o_overflow(ovf_s), .o_level(level_s)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Pulse counters, sampled away from the active edge.
  always @(negedge i_clk) begin
    if (uf_m)  uf_cnt_m++;
    if (uf_s)  uf_cnt_s++;
    if (ovf_m) ovf_cnt_m++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic push(input logic to_s, input logic [15:0] d);
    @(negedge i_clk);
    i_data = d;
    if (to_s) valid_s = 1'b1; else valid_m = 1'b1;
    @(negedge i_clk);
    valid_s = 1'b0;
    valid_m = 1'b0;
  endtask

  // One LRCK half of 32 BCLK. Bits are taken on the falling edge before each
  // codec rising edge, starting with the 2nd rising edge of the slot.
  task automatic slot(input logic lr, input logic do_push, input logic [15:0] pdata,
                      input int flip_at,
                      output logic [15:0] w_m, output logic [15:0] w_s,
                      output logic pad_m, output logic pad_s,
                      output logic [2:0] lvl1, output logic ovf1);
    w_m = '0; w_s = '0; pad_m = 1'b0; pad_s = 1'b0; lvl1 = '0; ovf1 = 1'b0;
    @(negedge i_clk);
    i_daclrck = lr;
    if (do_push) begin
      i_data  = pdata;
      valid_m = 1'b1;
    end
    @(posedge i_clk);
    for (int b = 0; b < 31; b++) begin
      @(negedge i_clk);
      if (b == 0) begin
        valid_m = 1'b0;
        lvl1    = level_m;
        ovf1    = ovf_m;
      end
      if (b == flip_at) i_enable = ~i_enable;
      if (b < 16) begin
        w_m = {w_m[14:0], dacdat_m};
        w_s = {w_s[14:0], dacdat_s};
      end else begin
        pad_m = pad_m | dacdat_m;
        pad_s = pad_s | dacdat_s;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b1; i_daclrck = 1'b1; i_data = '0;
    valid_m = 1'b0; valid_s = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++; if (dacdat_m !== 1'b0) begin n_bad++; $display("FAIL reset_dacdat got %b want 0", dacdat_m); end
    n_cmp++; if (level_m !== 3'd0)  begin n_bad++; $display("FAIL reset_level got %0d want 0", level_m); end
    n_cmp++; if (ready_m !== 1'b1)  begin n_bad++; $display("FAIL reset_ready got %b want 1", ready_m); end
    n_cmp++; if (uf_m !== 1'b0 || ovf_m !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got uf=%b ovf=%b want 0 0", uf_m, ovf_m); end
    n_cmp++; if (ready_s !== 1'b1 || level_s !== 3'd0 || ovf_s !== 1'b0) begin n_bad++; $display("FAIL reset_stereo got ready=%b level=%0d ovf=%b want 1 0 0", ready_s, level_s, ovf_s); end
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_single_sample();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1;
    push(1'b0, 16'hA5C3);
    n_cmp++; if (level_m !== 3'd1) begin n_bad++; $display("FAIL t1_level_push got %0d want 1", level_m); end
    slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'hA5C3) begin n_bad++; $display("FAIL t1_left got %h want a5c3", wm); end
    n_cmp++; if (pm !== 1'b0) begin n_bad++; $display("FAIL t1_left_pad got %b want 0", pm); end
    n_cmp++; if (l1 !== 3'd0) begin n_bad++; $display("FAIL t1_level_pop got %0d want 0", l1); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'hA5C3) begin n_bad++; $display("FAIL t1_right got %h want a5c3", wm); end
    n_cmp++; if (pm !== 1'b0) begin n_bad++; $display("FAIL t1_right_pad got %b want 0", pm); end
  endtask

  task automatic test_underflow();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1; int uf0;
    uf0 = uf_cnt_m;
    slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'h0000 || pm !== 1'b0) begin n_bad++; $display("FAIL t2_left got %h pad=%b want 0000 0", wm, pm); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'h0000 || pm !== 1'b0) begin n_bad++; $display("FAIL t2_right got %h pad=%b want 0000 0", wm, pm); end
    n_cmp++; if (uf_cnt_m - uf0 !== 1) begin n_bad++; $display("FAIL t2_underflow_pulses got %0d want 1", uf_cnt_m - uf0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1; int ovf0;
    logic [15:0] d [5];
    d[0] = 16'h1234; d[1] = 16'h8000; d[2] = 16'hFFFF; d[3] = 16'h0001; d[4] = 16'hDEAD;
    ovf0 = ovf_cnt_m;
    @(negedge i_clk);
    i_data = d[0]; valid_m = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge i_clk);
      if (k == 3) begin
        n_cmp++; if (ready_m !== 1'b1) begin n_bad++; $display("FAIL t3_ready_at3 got %b want 1", ready_m); end
      end
      if (k == 4) begin
        n_cmp++; if (ready_m !== 1'b0 || level_m !== 3'd4) begin n_bad++; $display("FAIL t3_full got ready=%b level=%0d want 0 4", ready_m, level_m); end
      end
      i_data = d[k];
    end
    @(negedge i_clk);
    valid_m = 1'b0;
    n_cmp++; if (ovf_m !== 1'b1) begin n_bad++; $display("FAIL t3_overflow got %b want 1", ovf_m); end
    repeat (2) @(negedge i_clk);
    n_cmp++; if (ovf_cnt_m - ovf0 !== 1) begin n_bad++; $display("FAIL t3_overflow_pulses got %0d want 1", ovf_cnt_m - ovf0); end
    for (int f = 0; f < 4; f++) begin
      slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
      n_cmp++; if (wm !== d[f]) begin n_bad++; $display("FAIL t3_left%0d got %h want %h", f, wm, d[f]); end
      slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
      n_cmp++; if (wm !== d[f]) begin n_bad++; $display("FAIL t3_right%0d got %h want %h", f, wm, d[f]); end
    end
    n_cmp++; if (level_m !== 3'd0) begin n_bad++; $display("FAIL t3_level_end got %0d want 0", level_m); end
  endtask

  task automatic test_full_pop_push();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1;
    logic [15:0] d [4];
    d[0] = 16'h0A0A; d[1] = 16'h0B0B; d[2] = 16'h0C0C; d[3] = 16'h0D0D;
    for (int k = 0; k < 4; k++) push(1'b0, d[k]);
    n_cmp++; if (level_m !== 3'd4) begin n_bad++; $display("FAIL t4_level_full got %0d want 4", level_m); end
    slot(1'b0, 1'b1, 16'hEEEE, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL t4_overflow got %b want 1", ov); end
    n_cmp++; if (l1 !== 3'd3) begin n_bad++; $display("FAIL t4_level_after got %0d want 3", l1); end
    n_cmp++; if (wm !== d[0]) begin n_bad++; $display("FAIL t4_left0 got %h want %h", wm, d[0]); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    for (int f = 1; f < 4; f++) begin
      slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
      n_cmp++; if (wm !== d[f]) begin n_bad++; $display("FAIL t4_left%0d got %h want %h", f, wm, d[f]); end
      slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    end
    n_cmp++; if (level_m !== 3'd0) begin n_bad++; $display("FAIL t4_level_end got %0d want 0", level_m); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1; int ufm0, ufs0, ones;
    push(1'b0, 16'hFFFF);
    push(1'b0, 16'h2222);
    @(negedge i_clk);
    i_daclrck = 1'b0;
    @(posedge i_clk);
    repeat (8) @(negedge i_clk);
    n_cmp++; if (dacdat_m !== 1'b1) begin n_bad++; $display("FAIL t5_bit7 got %b want 1", dacdat_m); end
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if (dacdat_m !== 1'b0) begin n_bad++; $display("FAIL t5_dacdat_async got %b want 0", dacdat_m); end
    n_cmp++; if (level_m !== 3'd0) begin n_bad++; $display("FAIL t5_level_flush got %0d want 0", level_m); end
    repeat (2) @(negedge i_clk);
    i_daclrck = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    ufm0 = uf_cnt_m; ufs0 = uf_cnt_s; ones = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (dacdat_m) ones++;
    end
    n_cmp++; if (ones !== 0) begin n_bad++; $display("FAIL t5_silent got %0d ones want 0", ones); end
    n_cmp++; if (uf_cnt_m !== ufm0 || uf_cnt_s !== ufs0) begin n_bad++; $display("FAIL t5_no_prime_edge got uf_m+%0d uf_s+%0d want 0 0", uf_cnt_m - ufm0, uf_cnt_s - ufs0); end
    push(1'b0, 16'h1357);
    slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'h1357) begin n_bad++; $display("FAIL t5_left got %h want 1357", wm); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (wm !== 16'h1357) begin n_bad++; $display("FAIL t5_right got %h want 1357", wm); end
  endtask

  task automatic test_stereo_enable();
    logic [15:0] wm, ws; logic pm, ps, ov; logic [2:0] l1;
    push(1'b1, 16'h8001);
    push(1'b1, 16'h7FFE);
    slot(1'b0, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h8001 || ps !== 1'b0) begin n_bad++; $display("FAIL t6_left got %h pad=%b want 8001 0", ws, ps); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h7FFE || ps !== 1'b0) begin n_bad++; $display("FAIL t6_right got %h pad=%b want 7ffe 0", ws, ps); end
    push(1'b1, 16'h1111);
    push(1'b1, 16'h2222);
    slot(1'b0, 1'b0, '0, 8, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h1111) begin n_bad++; $display("FAIL t6_disable_midslot got %h want 1111", ws); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h0000 || level_s !== 3'd1) begin n_bad++; $display("FAIL t6_disabled got %h level=%0d want 0000 1", ws, level_s); end
    slot(1'b0, 1'b0, '0, 8, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h0000 || level_s !== 3'd1) begin n_bad++; $display("FAIL t6_enable_midslot got %h level=%0d want 0000 1", ws, level_s); end
    slot(1'b1, 1'b0, '0, -1, wm, ws, pm, ps, l1, ov);
    n_cmp++; if (ws !== 16'h2222 || level_s !== 3'd0) begin n_bad++; $display("FAIL t6_reenabled got %h level=%0d want 2222 0", ws, level_s); end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_underflow();
    test_back_to_back();
    test_full_pop_push();
    test_reset_mid_word();
    test_stereo_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
